// File: rtl/wfg_interconnect_pkg.sv
// Shared types and constants for the waveform-generator Wishbone interconnect.
package wfg_interconnect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } ic_state_t;

  localparam int unsigned NULL_PAGE = 0;
  localparam int unsigned ERR_CNT_W = 8;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    if (v == {ERR_CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + ERR_CNT_W'(1);
    end
  endfunction

endpackage

// File: rtl/wfg_wb_addr_decode.sv
// Page decoder: slave i owns page NULL_PAGE+1+i; anything else is a miss.
module wfg_wb_addr_decode
  import wfg_interconnect_pkg::*;
#(
  parameter int BUSW       = 32,
  parameter int NUM_SLAVES = 3,
  parameter int PAGE_BITS  = 4
) (
  input  logic [BUSW-PAGE_BITS-1:0] page,
  output logic [NUM_SLAVES-1:0]     hit,
  output logic                      miss
);

  localparam int PW = BUSW - PAGE_BITS;

  // Full-width page compare so high address bits never alias onto a slave.
  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      hit[i] = (page == PW'(NULL_PAGE + 1 + i));
    end
    miss = ~|hit;
  end

endmodule

// File: rtl/wfg_wb_interconnect.sv
// Wishbone classic single-master to N-slave interconnect with bus errors,
// ack timeout, cycle abort and error address/count capture.
module wfg_wb_interconnect
  import wfg_interconnect_pkg::*;
#(
  parameter int BUSW       = 32,
  parameter int NUM_SLAVES = 3,
  parameter int PAGE_BITS  = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                         io_wbs_clk,
  input  logic                         io_wbs_rst,
  input  logic [BUSW-1:0]              io_wbs_adr,
  input  logic [BUSW-1:0]              io_wbs_datwr,
  input  logic                         io_wbs_we,
  input  logic                         io_wbs_stb,
  input  logic                         io_wbs_cyc,
  output logic [BUSW-1:0]              io_wbs_datrd,
  output logic                         io_wbs_ack,
  output logic                         io_wbs_err,
  output logic [NUM_SLAVES-1:0]        wbs_stb_o,
  output logic                         wbs_cyc_o,
  output logic                         wbs_we_o,
  output logic [PAGE_BITS-1:0]         wbs_adr_o,
  output logic [BUSW-1:0]              wbs_dat_o,
  input  logic [NUM_SLAVES-1:0]        wbs_ack_i,
  input  logic [NUM_SLAVES*BUSW-1:0]   wbs_dat_i,
  output logic [BUSW-1:0]              err_addr_o,
  output logic [ERR_CNT_W-1:0]         err_cnt_o
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  ic_state_t              state_r;
  logic [NUM_SLAVES-1:0]  stb_r;
  logic                   cyc_r;
  logic                   we_r;
  logic [BUSW-1:0]        adr_r;
  logic [BUSW-1:0]        dat_r;
  logic [BUSW-1:0]        datrd_r;
  logic                   ack_r;
  logic                   err_r;
  logic [BUSW-1:0]        err_addr_r;
  logic [ERR_CNT_W-1:0]   err_cnt_r;
  logic [CNT_W-1:0]       cnt_r;

  logic [NUM_SLAVES-1:0]  hit_s;
  logic                   miss_s;
  logic                   ack_sel_s;
  logic [BUSW-1:0]        dat_sel_s;
  logic                   timeout_hit_s;

  wfg_wb_addr_decode #(
    .BUSW       (BUSW),
    .NUM_SLAVES (NUM_SLAVES),
    .PAGE_BITS  (PAGE_BITS)
  ) u_decode (
    .page (io_wbs_adr[BUSW-1:PAGE_BITS]),
    .hit  (hit_s),
    .miss (miss_s)
  );

  // stb_r is one-hot while forwarding, so it doubles as the response select.
  always_comb begin
    dat_sel_s = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      dat_sel_s = dat_sel_s | (wbs_dat_i[i*BUSW +: BUSW] & {BUSW{stb_r[i]}});
    end
  end

  assign ack_sel_s     = |(wbs_ack_i & stb_r);
  assign timeout_hit_s = (TIMEOUT != 0) && (cnt_r == CNT_W'(TIMEOUT));

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge io_wbs_clk or posedge io_wbs_rst) begin
    if (io_wbs_rst) begin
      state_r    <= ST_IDLE;
      stb_r      <= '0;
      cyc_r      <= 1'b0;
      we_r       <= 1'b0;
      adr_r      <= '0;
      dat_r      <= '0;
      datrd_r    <= '0;
      ack_r      <= 1'b0;
      err_r      <= 1'b0;
      err_addr_r <= '0;
      err_cnt_r  <= '0;
      cnt_r      <= '0;
    end else begin
      ack_r <= 1'b0;
      err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (io_wbs_cyc && io_wbs_stb) begin
            adr_r <= io_wbs_adr;
            we_r  <= io_wbs_we;
            dat_r <= io_wbs_datwr;
            cnt_r <= '0;
            if (miss_s) begin
              state_r    <= ST_ERR;
              err_r      <= 1'b1;
              err_addr_r <= io_wbs_adr;
              err_cnt_r  <= sat_inc(err_cnt_r);
            end else begin
              state_r <= ST_FWD;
              stb_r   <= hit_s;
              cyc_r   <= 1'b1;
            end
          end
        end
        ST_FWD: begin
          // Abort beats ack, and ack beats a simultaneous timeout.
          if (!io_wbs_cyc) begin
            state_r <= ST_IDLE;
            stb_r   <= '0;
            cyc_r   <= 1'b0;
          end else if (ack_sel_s) begin
            state_r <= ST_RESP;
            datrd_r <= dat_sel_s;
            ack_r   <= 1'b1;
            stb_r   <= '0;
            cyc_r   <= 1'b0;
          end else if (timeout_hit_s) begin
            state_r    <= ST_ERR;
            err_r      <= 1'b1;
            err_addr_r <= adr_r;
            err_cnt_r  <= sat_inc(err_cnt_r);
            stb_r      <= '0;
            cyc_r      <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_RESP: begin
          state_r <= ST_IDLE;
        end
        ST_ERR: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          stb_r   <= '0;
          cyc_r   <= 1'b0;
        end
      endcase
    end
  end

  assign io_wbs_datrd = datrd_r;
  assign io_wbs_ack   = ack_r;
  assign io_wbs_err   = err_r;
  assign wbs_stb_o    = stb_r;
  assign wbs_cyc_o    = cyc_r;
  assign wbs_we_o     = we_r;
  assign wbs_adr_o    = adr_r[PAGE_BITS-1:0];
  assign wbs_dat_o    = dat_r;
  assign err_addr_o   = err_addr_r;
  assign err_cnt_o    = err_cnt_r;

endmodule

// File: tb/tb_wfg_wb_interconnect.sv
// Randomized bench for wfg_wb_interconnect with behavioural slaves and a
// transaction-level expectation model.
module tb_wfg_wb_interconnect;

  localparam int BUSW = 32;
  localparam int NS   = 3;
  localparam int PB   = 4;
  localparam int TO   = 255;

  logic              clk = 1'b0;
  logic              rst;
  logic [BUSW-1:0]   m_adr, m_datwr;
  logic              m_we, m_stb, m_cyc;
  logic [BUSW-1:0]   m_datrd;
  logic              m_ack, m_err;
  logic [NS-1:0]     s_stb;
  logic              s_cyc, s_we;
  logic [PB-1:0]     s_adr;
  logic [BUSW-1:0]   s_dat_o;
  logic [NS-1:0]     s_ack;
  logic [NS*BUSW-1:0] s_dat_i;
  logic [BUSW-1:0]   err_addr;
  logic [7:0]        err_cnt;

  always #5 clk = ~clk;

  wfg_wb_interconnect #(
    .BUSW(BUSW), .NUM_SLAVES(NS), .PAGE_BITS(PB), .TIMEOUT(TO)
  ) dut (
    .io_wbs_clk(clk), .io_wbs_rst(rst),
    .io_wbs_adr(m_adr), .io_wbs_datwr(m_datwr), .io_wbs_we(m_we),
    .io_wbs_stb(m_stb), .io_wbs_cyc(m_cyc),
    .io_wbs_datrd(m_datrd), .io_wbs_ack(m_ack), .io_wbs_err(m_err),
    .wbs_stb_o(s_stb), .wbs_cyc_o(s_cyc), .wbs_we_o(s_we),
    .wbs_adr_o(s_adr), .wbs_dat_o(s_dat_o),
    .wbs_ack_i(s_ack), .wbs_dat_i(s_dat_i),
    .err_addr_o(err_addr), .err_cnt_o(err_cnt)
  );

  // Behavioural slaves: ack after delay[i] strobe cycles, or never.
  logic [BUSW-1:0] smem [NS][16];
  int unsigned     delay [NS];
  bit              never [NS];
  int unsigned     wcnt [NS];
  logic [NS-1:0]   noise;

  always_comb begin
    s_ack   = '0;
    s_dat_i = '0;
    for (int i = 0; i < NS; i++) begin
      if (s_stb[i])
        s_ack[i] = s_cyc && !never[i] && (wcnt[i] >= delay[i]);
      else
        s_ack[i] = noise[i];
      s_dat_i[i*BUSW +: BUSW] = smem[i][s_adr];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (s_stb[i] && s_cyc && !s_ack[i]) wcnt[i] <= wcnt[i] + 1;
      else wcnt[i] <= 0;
      if (s_stb[i] && s_cyc && s_ack[i] && s_we) smem[i][s_adr] <= s_dat_o;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  int both_cnt = 0;

  always @(negedge clk) if (m_ack && m_err) both_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference state
  logic [BUSW-1:0] mmem [NS][16];
  logic [BUSW-1:0] exp_datrd = '0;
  logic [BUSW-1:0] exp_eaddr = '0;
  int              exp_cnt   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    noise = NS'($urandom);
  endtask

  task automatic run_txn(input logic [31:0] adr, input logic we, input logic [31:0] dat);
    logic [31:0] pg;
    bit          hit, exp_err;
    int          s, exp_cyc, ack_at, err_at;
    logic [3:0]  off;
    logic [NS-1:0] exp_stb;
    pg  = adr >> PB;
    off = adr[3:0];
    hit = (pg >= 1) && (pg <= NS);
    s   = hit ? int'(pg) - 1 : 0;
    exp_stb = hit ? NS'(1 << s) : '0;
    if (!hit) begin
      exp_err = 1; exp_cyc = 1;
    end else if (never[s] || delay[s] > TO) begin
      exp_err = 1; exp_cyc = TO + 2;
    end else begin
      exp_err = 0; exp_cyc = int'(delay[s]) + 2;
    end
    m_adr = adr; m_we = we; m_datwr = dat; m_cyc = 1'b1; m_stb = 1'b1;
    ack_at = 0; err_at = 0;
    for (int c = 1; c <= TO + 10; c++) begin
      tick();
      if (c == 1) begin
        check_eq("stb_onehot", 32'(s_stb), 32'(exp_stb));
        check_eq("cyc_o", 32'(s_cyc), 32'(hit));
        if (hit) begin
          check_eq("adr_o", 32'(s_adr), 32'(off));
          check_eq("we_o", 32'(s_we), 32'(we));
          check_eq("dat_o", s_dat_o, dat);
        end
      end
      if (m_ack) begin ack_at = c; break; end
      if (m_err) begin err_at = c; break; end
    end
    m_cyc = 1'b0; m_stb = 1'b0;
    if (!exp_err) begin
      check_eq("ack_cycle", 32'(ack_at), 32'(exp_cyc));
      exp_datrd = mmem[s][off];
      if (we) mmem[s][off] = dat;
    end else begin
      check_eq("err_cycle", 32'(err_at), 32'(exp_cyc));
      exp_eaddr = adr;
      if (exp_cnt < 255) exp_cnt++;
      check_eq("err_addr", err_addr, exp_eaddr);
      check_eq("err_cnt", 32'(err_cnt), 32'(exp_cnt));
      check_eq("stb_after_err", 32'(s_stb), 32'h0);
    end
    check_eq("datrd", m_datrd, exp_datrd);
    tick();
    check_eq("pulse_one_cycle", 32'({m_ack, m_err}), 32'h0);
  endtask

  task automatic run_abort(input logic [31:0] adr, input int k);
    int s;
    s = int'(adr >> PB) - 1;
    never[s] = 1'b1;
    m_adr = adr; m_we = 1'b0; m_datwr = '0; m_cyc = 1'b1; m_stb = 1'b1;
    for (int c = 1; c <= k; c++) tick();
    check_eq("abort_stb_held", 32'(s_stb), 32'(1 << s));
    m_cyc = 1'b0; m_stb = 1'b0;
    tick();
    check_eq("abort_stb_drop", 32'(s_stb), 32'h0);
    check_eq("abort_cyc_drop", 32'(s_cyc), 32'h0);
    for (int c = 0; c < 4; c++) begin
      check_eq("abort_no_resp", 32'({m_ack, m_err}), 32'h0);
      tick();
    end
    check_eq("abort_datrd", m_datrd, exp_datrd);
    check_eq("abort_err_cnt", 32'(err_cnt), 32'(exp_cnt));
    never[s] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          kind;
    for (int i = 0; i < NS; i++) begin
      delay[i] = 0; never[i] = 1'b0; wcnt[i] = 0;
      for (int j = 0; j < 16; j++) begin
        smem[i][j] = $urandom;
        mmem[i][j] = smem[i][j];
      end
    end
    noise = '0;
    m_adr = '0; m_datwr = '0; m_we = 1'b0; m_stb = 1'b0; m_cyc = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check_eq("rst_ack", 32'({m_ack, m_err}), 32'h0);
    check_eq("rst_stb", 32'({s_stb, s_cyc, s_we}), 32'h0);
    check_eq("rst_datrd", m_datrd, 32'h0);
    check_eq("rst_err", err_addr | 32'(err_cnt), 32'h0);
    rst = 1'b0;
    tick();

    // Directed cases
    smem[1][4] = 32'hDEADBEEF; mmem[1][4] = 32'hDEADBEEF;
    run_txn(32'h24, 1'b0, 32'h0);
    check_eq("plan_read", m_datrd, 32'hDEADBEEF);
    run_txn(32'h3C, 1'b1, 32'h1234);
    check_eq("plan_write_mem", smem[2][12], 32'h1234);
    run_txn(32'h08, 1'b0, 32'h0);
    check_eq("plan_null_cnt", 32'(err_cnt), 32'd1);
    run_txn(32'h1000_0014, 1'b0, 32'h0);
    never[0] = 1'b1;
    run_txn(32'h10, 1'b0, 32'h0);
    never[0] = 1'b0;
    delay[1] = 255;
    run_txn(32'h28, 1'b0, 32'h0);
    delay[1] = 256;
    run_txn(32'h2C, 1'b0, 32'h0);
    delay[1] = 0;
    run_abort(32'h18, 3);
    run_txn(32'h18, 1'b0, 32'h0);

    // Randomized mix of hits (reads/writes) and misses
    for (int n = 0; n < 200; n++) begin
      for (int i = 0; i < NS; i++) delay[i] = $urandom_range(0, 4);
      kind = $urandom_range(0, 9);
      if (kind < 7)      a = 32'(($urandom_range(1, NS) << PB) | $urandom_range(0, 15));
      else if (kind < 8) a = 32'($urandom_range(0, 15));
      else if (kind < 9) a = 32'(($urandom_range(NS + 1, 15) << PB) | $urandom_range(0, 15));
      else               a = $urandom | 32'h8000_0000;
      if (kind == 5) run_abort(32'(($urandom_range(1, NS)) << PB), $urandom_range(1, 5));
      else run_txn(a, 1'($urandom), $urandom);
    end

    // Error counter saturation
    for (int n = 0; n < 300; n++) run_txn(32'h0000_0004, 1'b0, 32'h0);
    check_eq("sat_cnt", 32'(err_cnt), 32'd255);

    // Async reset during forwarding, checked before any clock edge
    never[0] = 1'b1;
    m_adr = 32'h10; m_we = 1'b1; m_datwr = 32'hA5A5_5A5A; m_cyc = 1'b1; m_stb = 1'b1;
    repeat (3) tick();
    check_eq("pre_rst_stb", 32'(s_stb), 32'h1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_stb", 32'({s_stb, s_cyc, s_we}), 32'h0);
    check_eq("arst_adr_dat", 32'(s_adr) | s_dat_o, 32'h0);
    check_eq("arst_resp", 32'({m_ack, m_err}), 32'h0);
    check_eq("arst_datrd", m_datrd, 32'h0);
    check_eq("arst_err_addr", err_addr, 32'h0);
    check_eq("arst_err_cnt", 32'(err_cnt), 32'h0);
    m_cyc = 1'b0; m_stb = 1'b0;
    tick();
    rst = 1'b0;
    never[0] = 1'b0;
    exp_datrd = '0; exp_eaddr = '0; exp_cnt = 0;
    tick();
    run_txn(32'h14, 1'b0, 32'h0);
    run_txn(32'h44, 1'b0, 32'h0);

    check_eq("ack_err_exclusive", 32'(both_cnt), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
